// File: rtl/sprite_blitter.sv
// Purpose: copies or fills a rectangle from ROM into VGA plot commands, with screen-edge clipping and transparent-colour skipping.
// Latency: first plot ROM_LAT cycles after the first romAddr; done follows the last plot by one cycle.
// Backpressure: none; one pixel per cycle, and the VGA adapter must accept every plot.
module sprite_blitter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int ADDR_W   = 15,
    parameter int ROM_LAT  = 1,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     xOrigin,
    input  logic [Y_W-1:0]     yOrigin,
    input  logic [X_W-1:0]     rectW,
    input  logic [Y_W-1:0]     rectH,
    input  logic [ADDR_W-1:0]  romBase,
    input  logic               fillMode,
    input  logic [COLOR_W-1:0] fillColor,
    input  logic               transpEn,
    input  logic [COLOR_W-1:0] transpColor,
    output logic [ADDR_W-1:0]  romAddr,
    input  logic [COLOR_W-1:0] romData,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam int LAST = ROM_LAT - 1;
    localparam logic [1:0] DRAIN_INIT = 2'(ROM_LAT - 1);

    state_t             state;
    logic [X_W-1:0]     xOrgReg, wReg, col;
    logic [Y_W-1:0]     yOrgReg, hReg, row;
    logic [ADDR_W-1:0]  addr;
    logic               fillReg, transpReg;
    logic [COLOR_W-1:0] fillColorReg, transpColorReg;
    logic [1:0]         drainCnt;

    // Pixel-tracking pipeline, ROM_LAT deep so each entry lines up with its romData.
    logic               pipeValid [ROM_LAT];
    logic               pipeClip  [ROM_LAT];
    logic [X_W-1:0]     pipeX     [ROM_LAT];
    logic [Y_W-1:0]     pipeY     [ROM_LAT];

    logic [X_W-1:0]     xHold;
    logic [Y_W-1:0]     yHold;
    logic [COLOR_W-1:0] colorHold;

    logic [X_W:0]       sumX;
    logic [Y_W:0]       sumY;
    logic               issueClip, lastCol, lastRow;
    logic [COLOR_W-1:0] srcColor;
    logic               skipPix, plotNow;

    // Screen coordinates of the pixel being issued; the extra bit catches wrap-around.
    always_comb begin
        sumX      = {1'b0, xOrgReg} + {1'b0, col};
        sumY      = {1'b0, yOrgReg} + {1'b0, row};
        issueClip = sumX[X_W] | sumY[Y_W]
                  | (sumX >= (X_W+1)'(SCREEN_W))
                  | (sumY >= (Y_W+1)'(SCREEN_H));
        lastCol   = (col == wReg - X_W'(1));
        lastRow   = (row == hReg - Y_W'(1));
    end

    // Rectangle scan controller: latch the request, walk col/row/address, drain, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            addr           <= '0;
            col            <= '0;
            row            <= '0;
            xOrgReg        <= '0;
            yOrgReg        <= '0;
            wReg           <= '0;
            hReg           <= '0;
            fillReg        <= 1'b0;
            fillColorReg   <= '0;
            transpReg      <= 1'b0;
            transpColorReg <= '0;
            drainCnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xOrgReg        <= xOrigin;
                        yOrgReg        <= yOrigin;
                        wReg           <= rectW;
                        hReg           <= rectH;
                        addr           <= romBase;
                        fillReg        <= fillMode;
                        fillColorReg   <= fillColor;
                        transpReg      <= transpEn;
                        transpColorReg <= transpColor;
                        col            <= '0;
                        row            <= '0;
                        busy           <= 1'b1;
                        if (rectW == '0 || rectH == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    addr <= addr + ADDR_W'(1);
                    if (lastCol) begin
                        col <= '0;
                        row <= row + Y_W'(1);
                    end else begin
                        col <= col + X_W'(1);
                    end
                    if (lastCol && lastRow) begin
                        state    <= DRAIN;
                        drainCnt <= DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drainCnt <= drainCnt - 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift issued pixels down the pipeline; reset flushes every stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pipeValid[i] <= 1'b0;
                pipeClip[i]  <= 1'b0;
                pipeX[i]     <= '0;
                pipeY[i]     <= '0;
            end
        end else begin
            pipeValid[0] <= (state == SCAN);
            pipeClip[0]  <= issueClip;
            pipeX[0]     <= sumX[X_W-1:0];
            pipeY[0]     <= sumY[Y_W-1:0];
            for (int i = 1; i < ROM_LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeClip[i]  <= pipeClip[i-1];
                pipeX[i]     <= pipeX[i-1];
                pipeY[i]     <= pipeY[i-1];
            end
        end
    end

    // Final plot decision at the point where romData belongs to the last pipeline entry.
    always_comb begin
        srcColor = fillReg ? fillColorReg : romData;
        skipPix  = transpReg & ~fillReg & (romData == transpColorReg);
        plotNow  = pipeValid[LAST] & ~pipeClip[LAST] & ~skipPix;
    end

    // Remember the last plotted pixel so x/y/color stay put between plots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xHold     <= '0;
            yHold     <= '0;
            colorHold <= '0;
        end else if (plotNow) begin
            xHold     <= pipeX[LAST];
            yHold     <= pipeY[LAST];
            colorHold <= srcColor;
        end
    end

    assign romAddr = addr;
    assign plot    = plotNow;
    assign x       = plotNow ? pipeX[LAST] : xHold;
    assign y       = plotNow ? pipeY[LAST] : yHold;
    assign color   = plotNow ? srcColor    : colorHold;

endmodule

// File: tb/tb_sprite_blitter.sv
// Purpose: scoreboard bench for sprite_blitter at ROM_LAT=1 and ROM_LAT=3.
// Latency: expected plots carry the exact cycle they must appear in.
// Backpressure: none; the monitors accept every plot.
module tb_sprite_blitter;

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic [7:0]  xOrg = '0, rW = '0;
    logic [6:0]  yOrg = '0, rH = '0;
    logic [14:0] base = '0;
    logic        fm = 1'b0, te = 1'b0;
    logic [2:0]  fc = '0, tc = '0;

    logic [14:0] romAddr1, romAddr3;
    logic [2:0]  romQ1 = '0, romQ3 = '0;
    logic [14:0] r3a = '0, r3b = '0;
    logic [7:0]  x1, x3;
    logic [6:0]  y1, y3;
    logic [2:0]  color1, color3;
    logic        plot1, plot3, busy1, busy3, done1, done3;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pc1 = 0, pc3 = 0;
    exp_t q1[$], q3[$];
    int   dq1[$], dq3[$];
    exp_t e1, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: q = address[2:0], ROM_LAT cycles after the address
    always @(posedge clk) romQ1 <= romAddr1[2:0];
    always @(posedge clk) begin
        r3a   <= romAddr3;
        r3b   <= r3a;
        romQ3 <= r3b[2:0];
    end

    sprite_blitter #(.ROM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .xOrigin(xOrg), .yOrigin(yOrg), .rectW(rW), .rectH(rH), .romBase(base),
        .fillMode(fm), .fillColor(fc), .transpEn(te), .transpColor(tc),
        .romAddr(romAddr1), .romData(romQ1),
        .x(x1), .y(y1), .color(color1), .plot(plot1), .busy(busy1), .done(done1)
    );

    sprite_blitter #(.ROM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .xOrigin(xOrg), .yOrigin(yOrg), .rectW(rW), .rectH(rH), .romBase(base),
        .fillMode(fm), .fillColor(fc), .transpEn(te), .transpColor(tc),
        .romAddr(romAddr3), .romData(romQ3),
        .x(x3), .y(y3), .color(color3), .plot(plot3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected plots and done cycle for a rectangle accepted so that cyc==acc right after the accepting edge
    task automatic pushRect(input int lat, input int acc, input int x0, input int y0, input int w,
                            input int h, input int b, input bit fmode, input int fcol,
                            input bit tEn, input int tCol);
        int n;
        n = w * h;
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int   romVal;
            bit   clipped, skip;
            e.x     = x0 + (k % w);
            e.y     = y0 + (k / w);
            e.cyc   = acc + k + lat;
            romVal  = (b + k) & 7;
            e.c     = fmode ? fcol : romVal;
            clipped = (e.x >= 160) || (e.y >= 120);
            skip    = tEn && !fmode && (romVal == tCol);
            if (!clipped && !skip) begin
                if (lat == 1) q1.push_back(e);
                else          q3.push_back(e);
            end
        end
        if (lat == 1) dq1.push_back(n == 0 ? acc : acc + n + lat);
        else          dq3.push_back(n == 0 ? acc : acc + n + lat);
    endtask

    // Called at a negedge; asserts start for one edge and returns at the next negedge
    task automatic issue(input int lat, input int x0, input int y0, input int w, input int h,
                         input int b, input bit fmode, input int fcol, input bit tEn, input int tCol);
        xOrg = 8'(x0);
        yOrg = 7'(y0);
        rW   = 8'(w);
        rH   = 7'(h);
        base = 15'(b);
        fm   = fmode;
        fc   = 3'(fcol);
        te   = tEn;
        tc   = 3'(tCol);
        pushRect(lat, cyc + 1, x0, y0, w, h, b, fmode, fcol, tEn, tCol);
        if (lat == 1) start1 = 1'b1;
        else          start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        // scramble inputs: accepted requests must not see later changes
        xOrg = 8'd99;
        yOrg = 7'd99;
        rW   = 8'd7;
        rH   = 7'd7;
        fm   = ~fmode;
        fc   = 3'd6;
        te   = ~tEn;
        tc   = 3'd5;
    endtask

    // Monitor for the ROM_LAT=1 instance
    always @(negedge clk) begin
        if (plot1) begin
            pc1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat1 unexpected plot x=%0d y=%0d actual=plot required=no plot (cycle %0d)", x1, y1, cyc);
            end else begin
                e1 = q1.pop_front();
                chk("lat1 plot cycle", cyc, e1.cyc);
                chk("lat1 plot x", int'(x1), e1.x);
                chk("lat1 plot y", int'(y1), e1.y);
                chk("lat1 plot color", int'(color1), e1.c);
            end
        end
        if (done1) begin
            if (dq1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat1 unexpected done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                chk("lat1 done cycle", cyc, dq1.pop_front());
            end
        end
    end

    // Monitor for the ROM_LAT=3 instance
    always @(negedge clk) begin
        if (plot3) begin
            pc3++;
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat3 unexpected plot x=%0d y=%0d actual=plot required=no plot (cycle %0d)", x3, y3, cyc);
            end else begin
                e3 = q3.pop_front();
                chk("lat3 plot cycle", cyc, e3.cyc);
                chk("lat3 plot x", int'(x3), e3.x);
                chk("lat3 plot y", int'(y3), e3.y);
                chk("lat3 plot color", int'(color3), e3.c);
            end
        end
        if (done3) begin
            if (dq3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat3 unexpected done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                chk("lat3 done cycle", cyc, dq3.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int pcSave;

        repeat (3) @(negedge clk);
        chk("reset romAddr", int'(romAddr1), 0);
        chk("reset x", int'(x1), 0);
        chk("reset y", int'(y1), 0);
        chk("reset color", int'(color1), 0);
        chk("reset plot", int'(plot1), 0);
        chk("reset busy", int'(busy1), 0);
        chk("reset done", int'(done1), 0);
        chk("reset lat3 busy", int'(busy3), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 4x2 copy at (10,20), base 100: colours 4,5,6,7,0,1,2,3
        pcSave = pc1;
        issue(1, 10, 20, 4, 2, 100, 1'b0, 0, 1'b0, 0);
        chk("copy busy after accept", int'(busy1), 1);
        repeat (11) @(negedge clk);
        chk("copy plot count", pc1 - pcSave, 8);
        chk("copy busy after done", int'(busy1), 0);
        chk("copy hold x", int'(x1), 13);
        chk("copy hold y", int'(y1), 21);
        chk("copy hold color", int'(color1), 3);
        chk("copy romAddr end", int'(romAddr1), 108);

        // same rectangle, colour 0 transparent: (10,21) missing
        pcSave = pc1;
        issue(1, 10, 20, 4, 2, 100, 1'b0, 0, 1'b1, 0);
        repeat (11) @(negedge clk);
        chk("transp plot count", pc1 - pcSave, 7);

        // fill 4x1 from x=158: only x=158,159 plotted, address still walks 4
        pcSave = pc1;
        issue(1, 158, 5, 4, 1, 200, 1'b1, 5, 1'b0, 0);
        repeat (7) @(negedge clk);
        chk("clip plot count", pc1 - pcSave, 2);
        chk("clip romAddr end", int'(romAddr1), 204);
        chk("clip hold x", int'(x1), 159);
        chk("clip hold color", int'(color1), 5);

        // zero width: done at once, then a 1x1 started in the first idle cycle
        pcSave = pc1;
        issue(1, 20, 20, 0, 3, 0, 1'b0, 0, 1'b0, 0);
        chk("zero busy", int'(busy1), 1);
        chk("zero done", int'(done1), 1);
        @(negedge clk);
        chk("zero busy after", int'(busy1), 0);
        issue(1, 3, 4, 1, 1, 9, 1'b0, 0, 1'b0, 0);
        repeat (5) @(negedge clk);
        chk("zero+1x1 plot count", pc1 - pcSave, 1);

        // ROM_LAT=3, 2x2 with address wrap 0x7FFE -> 0x0001
        issue(3, 50, 60, 2, 2, 32766, 1'b0, 0, 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("lat3 plot count", pc3, 4);
        chk("lat3 romAddr wrap", int'(romAddr3), 2);

        // reset in the middle of a 40x40 scan
        issue(1, 0, 0, 40, 40, 0, 1'b0, 0, 1'b0, 0);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset romAddr", int'(romAddr1), 0);
        chk("midreset x", int'(x1), 0);
        chk("midreset y", int'(y1), 0);
        chk("midreset color", int'(color1), 0);
        chk("midreset plot", int'(plot1), 0);
        chk("midreset busy", int'(busy1), 0);
        chk("midreset done", int'(done1), 0);
        q1.delete();
        dq1.delete();
        pcSave = pc1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("postreset plot count", pc1 - pcSave, 0);
        chk("postreset busy", int'(busy1), 0);

        // a fresh request after reset works normally
        issue(1, 7, 8, 1, 1, 3, 1'b0, 0, 1'b0, 0);
        repeat (5) @(negedge clk);
        chk("postreset new plot count", pc1 - pcSave, 1);

        chk("lat1 plots outstanding", q1.size(), 0);
        chk("lat3 plots outstanding", q3.size(), 0);
        chk("lat1 done outstanding", dq1.size(), 0);
        chk("lat3 done outstanding", dq3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
